// File: rtl/cpu_mult_pkg.sv
// Shared derivations and helpers for the sliced pipelined multiplier:
// slice count, partial-product width, slice extraction, config check.
package cpu_mult_pkg;

    localparam int MAX_W = 256;

    function automatic int nsl_of(input int width, input int chunk);
        return width / chunk;
    endfunction

    function automatic int ppw_of(input int chunk);
        return 2 * chunk + 1;
    endfunction

    function automatic bit cfg_ok(input int width, input int chunk);
        return (chunk > 0) && (width % chunk == 0) && (width <= MAX_W);
    endfunction

    function automatic logic [MAX_W-1:0] slice_of(
        input logic [MAX_W-1:0] v,
        input int               idx,
        input int               chunk
    );
        logic [MAX_W-1:0] w_mask;
        w_mask = ~({MAX_W{1'b1}} << chunk);
        return (v >> (idx * chunk)) & w_mask;
    endfunction

endpackage

// File: rtl/cpu_mult_pp_slice.sv
// One CHUNKxCHUNK slice multiplier with per-side signedness.
// Purely combinational so it maps onto a single DSP block.
module cpu_mult_pp_slice #(
    parameter int CHUNK = 16
) (
    input  logic [CHUNK-1:0]      i_a,
    input  logic [CHUNK-1:0]      i_b,
    input  logic                  i_a_signed,
    input  logic                  i_b_signed,
    output logic signed [2*CHUNK:0] o_pp
);

    logic signed [2*CHUNK:0] w_a;
    logic signed [2*CHUNK:0] w_b;

    // The exact product always fits in 2*CHUNK+1 signed bits.
    assign w_a  = {{(CHUNK+1){i_a_signed & i_a[CHUNK-1]}}, i_a};
    assign w_b  = {{(CHUNK+1){i_b_signed & i_b[CHUNK-1]}}, i_b};
    assign o_pp = w_a * w_b;

endmodule

// File: rtl/cpu_mult_pipe.sv
// Pipelined sliced multiplier: S1 partial products, S2 sum,
// optional S3 output register, valid/ready with flush.
module cpu_mult_pipe
    import cpu_mult_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int CHUNK   = 16,
    parameter int OUT_REG = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_src1,
    input  logic [WIDTH-1:0]   in_src2,
    input  logic               in_src1_signed,
    input  logic               in_src2_signed,
    input  logic               in_hi_sel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_product,
    output logic [WIDTH-1:0]   out_result,
    output logic               busy
);

    localparam int NSL = nsl_of(WIDTH, CHUNK);
    localparam int PPW = ppw_of(CHUNK);
    localparam int PW2 = 2 * WIDTH;

    if (!cfg_ok(WIDTH, CHUNK)) begin : g_cfg_err
        $error("cpu_mult_pipe: WIDTH must be a multiple of CHUNK");
    end

    logic [CHUNK-1:0]      w_sl1 [NSL];
    logic [CHUNK-1:0]      w_sl2 [NSL];
    logic signed [PPW-1:0] w_pp  [NSL*NSL];

    logic                  r_s1_v;
    logic                  r_s1_hi;
    logic signed [PPW-1:0] r_s1_pp [NSL*NSL];

    logic                  r_s2_v;
    logic                  r_s2_hi;
    logic [PW2-1:0]        r_s2_prod;

    logic [PW2-1:0]        w_sum;
    logic                  w_rdy1;
    logic                  w_rdy2;
    logic                  w_rdy_tail;
    logic                  w_s3_v;
    logic                  w_last_v;
    logic                  w_last_hi;
    logic [PW2-1:0]        w_last_prod;

    for (genvar g = 0; g < NSL; g++) begin : g_sl
        assign w_sl1[g] = CHUNK'(slice_of(MAX_W'(in_src1), g, CHUNK));
        assign w_sl2[g] = CHUNK'(slice_of(MAX_W'(in_src2), g, CHUNK));
    end

    // Only the top slice of an operand carries its sign.
    for (genvar i = 0; i < NSL; i++) begin : g_row
        for (genvar j = 0; j < NSL; j++) begin : g_col
            cpu_mult_pp_slice #(
                .CHUNK(CHUNK)
            ) u_pp (
                .i_a       (w_sl1[i]),
                .i_b       (w_sl2[j]),
                .i_a_signed((i == NSL-1) ? in_src1_signed : 1'b0),
                .i_b_signed((j == NSL-1) ? in_src2_signed : 1'b0),
                .o_pp      (w_pp[i*NSL+j])
            );
        end
    end

    assign w_rdy2   = !r_s2_v || w_rdy_tail;
    assign w_rdy1   = !r_s1_v || w_rdy2;
    assign in_ready = w_rdy1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_s1_v  <= 1'b0;
            r_s1_hi <= 1'b0;
            for (int k = 0; k < NSL*NSL; k++) begin
                r_s1_pp[k] <= '0;
            end
        end else begin
            if (flush) begin
                r_s1_v <= 1'b0;
            end else if (w_rdy1) begin
                r_s1_v <= in_valid;
            end
            if (w_rdy1 && in_valid) begin
                r_s1_hi <= in_hi_sel;
                for (int k = 0; k < NSL*NSL; k++) begin
                    r_s1_pp[k] <= w_pp[k];
                end
            end
        end
    end

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < NSL; i++) begin
            for (int j = 0; j < NSL; j++) begin
                w_sum = w_sum
                      + (PW2'(r_s1_pp[i*NSL+j]) << ((i + j) * CHUNK));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_s2_v    <= 1'b0;
            r_s2_hi   <= 1'b0;
            r_s2_prod <= '0;
        end else begin
            if (flush) begin
                r_s2_v <= 1'b0;
            end else if (w_rdy2) begin
                r_s2_v <= r_s1_v;
            end
            if (w_rdy2 && r_s1_v) begin
                r_s2_hi   <= r_s1_hi;
                r_s2_prod <= w_sum;
            end
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        logic           r_s3_v;
        logic           r_s3_hi;
        logic [PW2-1:0] r_s3_prod;

        assign w_rdy_tail = !r_s3_v || out_ready;

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                r_s3_v    <= 1'b0;
                r_s3_hi   <= 1'b0;
                r_s3_prod <= '0;
            end else begin
                if (flush) begin
                    r_s3_v <= 1'b0;
                end else if (w_rdy_tail) begin
                    r_s3_v <= r_s2_v;
                end
                if (w_rdy_tail && r_s2_v) begin
                    r_s3_hi   <= r_s2_hi;
                    r_s3_prod <= r_s2_prod;
                end
            end
        end

        assign w_s3_v      = r_s3_v;
        assign w_last_v    = r_s3_v;
        assign w_last_hi   = r_s3_hi;
        assign w_last_prod = r_s3_prod;
    end else begin : g_noreg
        assign w_rdy_tail  = out_ready;
        assign w_s3_v      = 1'b0;
        assign w_last_v    = r_s2_v;
        assign w_last_hi   = r_s2_hi;
        assign w_last_prod = r_s2_prod;
    end

    assign out_valid   = w_last_v;
    assign out_product = w_last_prod;
    assign out_result  = w_last_hi ? w_last_prod[PW2-1:WIDTH]
                                   : w_last_prod[WIDTH-1:0];
    assign busy        = r_s1_v | r_s2_v | w_s3_v;

endmodule

// File: tb/tb_cpu_mult_pipe.sv
// Directed and table-driven checks of cpu_mult_pipe in its default
// 32/16/OUT_REG=1 form and a 16/8/OUT_REG=0 form.
module tb_cpu_mult_pipe;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    logic        a_flush, a_valid, a_rdy, a_s1s, a_s2s, a_hi;
    logic        a_ov, a_or, a_busy;
    logic [31:0] a_s1, a_s2, a_res;
    logic [63:0] a_prod;

    logic        b_flush, b_valid, b_rdy, b_s1s, b_s2s, b_hi;
    logic        b_ov, b_or, b_busy;
    logic [15:0] b_s1, b_s2, b_res;
    logic [31:0] b_prod;

    cpu_mult_pipe u_a (
        .clk           (clk),
        .reset_n       (reset_n),
        .flush         (a_flush),
        .in_valid      (a_valid),
        .in_ready      (a_rdy),
        .in_src1       (a_s1),
        .in_src2       (a_s2),
        .in_src1_signed(a_s1s),
        .in_src2_signed(a_s2s),
        .in_hi_sel     (a_hi),
        .out_valid     (a_ov),
        .out_ready     (a_or),
        .out_product   (a_prod),
        .out_result    (a_res),
        .busy          (a_busy)
    );

    cpu_mult_pipe #(
        .WIDTH  (16),
        .CHUNK  (8),
        .OUT_REG(0)
    ) u_b (
        .clk           (clk),
        .reset_n       (reset_n),
        .flush         (b_flush),
        .in_valid      (b_valid),
        .in_ready      (b_rdy),
        .in_src1       (b_s1),
        .in_src2       (b_s2),
        .in_src1_signed(b_s1s),
        .in_src2_signed(b_s2s),
        .in_hi_sel     (b_hi),
        .out_valid     (b_ov),
        .out_ready     (b_or),
        .out_product   (b_prod),
        .out_result    (b_res),
        .busy          (b_busy)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sa;
        logic        sb;
        logic        hi;
        logic [63:0] prod;
        logic [31:0] res;
    } vec_t;

    typedef struct {
        logic [31:0] prod;
        logic [15:0] res;
    } exp_t;

    int   n_chk  = 0;
    int   n_fail = 0;
    vec_t tbl[9];
    exp_t q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ref16(input logic [15:0] a,
                                          input logic [15:0] b,
                                          input logic sa, input logic sb);
        longint ea, eb, p;
        ea = sa ? longint'($signed(a)) : longint'(a);
        eb = sb ? longint'($signed(b)) : longint'(b);
        p  = ea * eb;
        return p[31:0];
    endfunction

    task automatic run_a(input string nm, input logic [31:0] x,
                         input logic [31:0] y, input logic sx,
                         input logic sy, input logic hi,
                         input logic [63:0] ep, input logic [31:0] er);
        int lat;
        a_or = 1'b1;
        a_valid = 1'b1;
        a_s1 = x;
        a_s2 = y;
        a_s1s = sx;
        a_s2s = sy;
        a_hi = hi;
        #1;
        chk({nm, "_in_ready"}, 64'(a_rdy), 64'd1);
        tick();
        a_valid = 1'b0;
        lat = 1;
        while (!a_ov && lat < 10) begin
            tick();
            lat++;
        end
        chk({nm, "_latency"}, 64'(lat), 64'd3);
        chk({nm, "_prod"}, a_prod, ep);
        chk({nm, "_res"}, 64'(a_res), 64'(er));
        tick();
    endtask

    task automatic run_b(input string nm, input logic [15:0] x,
                         input logic [15:0] y, input logic sx,
                         input logic sy, input logic hi,
                         input logic [31:0] ep, input logic [15:0] er);
        int lat;
        b_or = 1'b1;
        b_valid = 1'b1;
        b_s1 = x;
        b_s2 = y;
        b_s1s = sx;
        b_s2s = sy;
        b_hi = hi;
        #1;
        tick();
        b_valid = 1'b0;
        lat = 1;
        while (!b_ov && lat < 10) begin
            tick();
            lat++;
        end
        chk({nm, "_latency"}, 64'(lat), 64'd2);
        chk({nm, "_prod"}, 64'(b_prod), 64'(ep));
        chk({nm, "_res"}, 64'(b_res), 64'(er));
        tick();
    endtask

    task automatic fill3();
        a_or = 1'b1;
        a_s1s = 1'b0;
        a_s2s = 1'b0;
        a_hi = 1'b0;
        for (int k = 0; k < 3; k++) begin
            a_valid = 1'b1;
            a_s1 = 32'(k + 1);
            a_s2 = 32'd10;
            tick();
        end
    endtask

    initial begin
        int idx;
        int n;
        int cyc;
        logic [63:0] bp_exp[4];
        exp_t e;

        tbl[0] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0,
                   64'hFFFF_FFFE_0000_0001, 32'h0000_0001};
        tbl[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1,
                   64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFE};
        tbl[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1,
                   64'h0000_0000_0000_0001, 32'h0000_0000};
        tbl[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0,
                   64'hFFFF_FFFF_0000_0001, 32'h0000_0001};
        tbl[4] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 1'b1,
                   64'h4000_0000_0000_0000, 32'h4000_0000};
        tbl[5] = '{32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0, 1'b1,
                   64'h0000_0001_0000_0000, 32'h0000_0001};
        tbl[6] = '{32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 1'b1, 1'b0,
                   64'hFFFF_FFFF_FFFF_FFFA, 32'hFFFF_FFFA};
        tbl[7] = '{32'h0000_0002, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1,
                   64'hFFFF_FFFF_FFFF_FFFE, 32'hFFFF_FFFF};
        tbl[8] = '{32'h1234_5678, 32'h0000_0010, 1'b0, 1'b0, 1'b0,
                   64'h0000_0001_2345_6780, 32'h2345_6780};
        bp_exp = '{64'd2, 64'd12, 64'd30, 64'd56};

        reset_n = 1'b0;
        a_flush = 1'b0; a_valid = 1'b0; a_or = 1'b0;
        a_s1 = '0; a_s2 = '0; a_s1s = 1'b0; a_s2s = 1'b0; a_hi = 1'b0;
        b_flush = 1'b0; b_valid = 1'b0; b_or = 1'b0;
        b_s1 = '0; b_s2 = '0; b_s1s = 1'b0; b_s2s = 1'b0; b_hi = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        #1;
        chk("rst_a_out_valid", 64'(a_ov), 64'd0);
        chk("rst_a_product", a_prod, 64'd0);
        chk("rst_a_result", 64'(a_res), 64'd0);
        chk("rst_a_busy", 64'(a_busy), 64'd0);
        chk("rst_a_in_ready", 64'(a_rdy), 64'd1);
        chk("rst_b_out_valid", 64'(b_ov), 64'd0);
        chk("rst_b_busy", 64'(b_busy), 64'd0);
        chk("rst_b_in_ready", 64'(b_rdy), 64'd1);
        tick();

        for (int i = 0; i < 9; i++) begin
            run_a($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].sa,
                  tbl[i].sb, tbl[i].hi, tbl[i].prod, tbl[i].res);
        end

        // Backpressure: four ops while the consumer stalls.
        a_or = 1'b0;
        a_s1s = 1'b0; a_s2s = 1'b0; a_hi = 1'b0;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            a_valid = (idx < 4);
            a_s1 = 32'(2 * idx + 1);
            a_s2 = 32'(2 * idx + 2);
            #1;
            if (a_valid && a_rdy) idx++;
            tick();
        end
        chk("bp_accepted", 64'(idx), 64'd3);
        chk("bp_in_ready_full", 64'(a_rdy), 64'd0);
        chk("bp_out_valid_held", 64'(a_ov), 64'd1);
        chk("bp_head_held", a_prod, 64'd2);
        a_or = 1'b1;
        n = 0;
        cyc = 0;
        while (n < 4 && cyc < 12) begin
            a_valid = (idx < 4);
            a_s1 = 32'(2 * idx + 1);
            a_s2 = 32'(2 * idx + 2);
            #1;
            if (a_ov) begin
                chk($sformatf("bp_prod%0d", n), a_prod, bp_exp[n]);
                chk($sformatf("bp_cycle%0d", n), 64'(cyc), 64'(n));
                n++;
            end
            if (a_valid && a_rdy) idx++;
            tick();
            cyc++;
        end
        a_valid = 1'b0;
        chk("bp_count", 64'(n), 64'd4);
        tick();

        // Flush with a live operand offered in the flush cycle.
        fill3();
        a_s1 = 32'd5;
        a_s2 = 32'd5;
        a_flush = 1'b1;
        tick();
        a_flush = 1'b0;
        a_valid = 1'b0;
        #1;
        chk("flush_out_valid", 64'(a_ov), 64'd0);
        chk("flush_busy", 64'(a_busy), 64'd0);
        chk("flush_in_ready", 64'(a_rdy), 64'd1);
        run_a("post_flush", 32'd9, 32'd9, 1'b0, 1'b0, 1'b0,
              64'd81, 32'd81);

        // Reset mid-stream, with flush also asserted.
        fill3();
        reset_n = 1'b0;
        a_flush = 1'b1;
        tick();
        reset_n = 1'b1;
        a_flush = 1'b0;
        a_valid = 1'b0;
        #1;
        chk("mrst_out_valid", 64'(a_ov), 64'd0);
        chk("mrst_product", a_prod, 64'd0);
        chk("mrst_result", 64'(a_res), 64'd0);
        chk("mrst_busy", 64'(a_busy), 64'd0);
        chk("mrst_in_ready", 64'(a_rdy), 64'd1);
        run_a("post_rst", 32'd9, 32'd9, 1'b0, 1'b0, 1'b0,
              64'd81, 32'd81);

        run_b("b_neg2x3", 16'hFFFE, 16'h0003, 1'b1, 1'b1, 1'b0,
              32'hFFFF_FFFA, 16'hFFFA);
        run_b("b_neg2x3_hi", 16'hFFFE, 16'h0003, 1'b1, 1'b1, 1'b1,
              32'hFFFF_FFFA, 16'hFFFF);
        run_b("b_max_u", 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b1,
              32'hFFFE_0001, 16'hFFFE);

        // Random sweep with random backpressure, scoreboard-checked.
        for (int c = 0; c < 300; c++) begin
            b_valid = ($urandom_range(0, 3) != 0);
            b_s1 = 16'($urandom);
            b_s2 = 16'($urandom);
            b_s1s = 1'($urandom);
            b_s2s = 1'($urandom);
            b_hi = 1'($urandom);
            b_or = ($urandom_range(0, 3) != 0);
            #1;
            if (b_ov && b_or) begin
                if (q.size() == 0) begin
                    chk("b_rand_spurious", 64'(b_ov), 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("b_rand_prod", 64'(b_prod), 64'(e.prod));
                    chk("b_rand_res", 64'(b_res), 64'(e.res));
                end
            end
            if (b_valid && b_rdy) begin
                e.prod = ref16(b_s1, b_s2, b_s1s, b_s2s);
                e.res = b_hi ? e.prod[31:16] : e.prod[15:0];
                q.push_back(e);
            end
            tick();
        end
        b_valid = 1'b0;
        b_or = 1'b1;
        for (int c = 0; c < 20 && q.size() > 0; c++) begin
            #1;
            if (b_ov) begin
                e = q.pop_front();
                chk("b_drain_prod", 64'(b_prod), 64'(e.prod));
                chk("b_drain_res", 64'(b_res), 64'(e.res));
            end
            tick();
        end
        chk("b_drain_empty", 64'(q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
